// File: rtl/ddc_tune_controller.sv
// rtl/ddc_tune_controller.sv - round-robin NCO retune sequencer with sample-aligned load and DDC flush blanking (option: DDC_TUNE_PHASE_CLR_EN)
module ddc_tune_controller #(
    parameter int FTW_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_req_valid,
    input  logic [FTW_WIDTH-1:0]   host_req_ftw,
    output logic                   host_req_ready,
    input  logic                   scan_req_valid,
    input  logic [FTW_WIDTH-1:0]   scan_req_ftw,
    output logic                   scan_req_ready,
    input  logic                   sample_valid,
    input  logic                   ddc_valid_in,
    output logic                   ddc_valid_out,
    output logic [FTW_WIDTH-1:0]   nco_ftw,
    output logic                   nco_ftw_load,
    output logic                   nco_phase_clr,
    output logic                   busy,
    output logic                   last_grant,
    output logic [COUNT_WIDTH-1:0] retune_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SAMPLE = 2'd1,
        FLUSH       = 2'd2
    } state_t;

    localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES);

    state_t               state;
    state_t               state_next;
    logic [FTW_WIDTH-1:0] pending;
    logic [7:0]           flush_cnt;
    logic                 grant_host;
    logic                 grant_scan;
    logic                 handshake;
    logic                 load_now;

    // Round-robin arbitration, IDLE-only readies and next-state selection
    always_comb begin
        grant_host     = host_req_valid & (~scan_req_valid | last_grant);
        grant_scan     = scan_req_valid & (~host_req_valid | ~last_grant);
        host_req_ready = (state == IDLE) & ~rst & grant_host;
        scan_req_ready = (state == IDLE) & ~rst & grant_scan;
        handshake      = host_req_ready | scan_req_ready;
        load_now       = (state == WAIT_SAMPLE) & sample_valid;
        state_next     = state;
        case (state)
            IDLE:        if (handshake) state_next = WAIT_SAMPLE;
            WAIT_SAMPLE: if (sample_valid) state_next = FLUSH;
            FLUSH:       if (flush_cnt == 8'd1) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, NCO word/strobe, flush countdown and retune counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            flush_cnt    <= '0;
            nco_ftw      <= '0;
            nco_ftw_load <= 1'b0;
            busy         <= 1'b0;
            last_grant   <= 1'b1;
            retune_count <= '0;
        end else begin
            busy         <= (state_next != IDLE);
            nco_ftw_load <= load_now;
            if (handshake) begin
                pending    <= grant_scan ? scan_req_ftw : host_req_ftw;
                last_grant <= grant_scan;
            end
            if (load_now) begin
                nco_ftw      <= pending;
                retune_count <= retune_count + COUNT_WIDTH'(1);
                flush_cnt    <= FLUSH_INIT;
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 8'd1;
            end
        end
    end

`ifdef DDC_TUNE_PHASE_CLR_EN
    // Phase-coherent retune: clear the accumulator alongside every load
    always_ff @(posedge clk) begin
        if (rst) begin
            nco_phase_clr <= 1'b0;
        end else begin
            nco_phase_clr <= load_now;
        end
    end
`else
    assign nco_phase_clr = 1'b0;
`endif

    assign ddc_valid_out = ddc_valid_in & (state != FLUSH) & ~rst;

endmodule

// File: tb/tb_ddc_tune_controller.sv
// tb/tb_ddc_tune_controller.sv - randomized and directed self-checking bench for ddc_tune_controller
module tb_ddc_tune_controller;

    localparam int FW = 32;
    localparam int FL = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req_valid = 1'b0;
    logic [FW-1:0] host_req_ftw = '0;
    logic          host_req_ready;
    logic          scan_req_valid = 1'b0;
    logic [FW-1:0] scan_req_ftw = '0;
    logic          scan_req_ready;
    logic          sample_valid = 1'b0;
    logic          ddc_valid_in = 1'b0;
    logic          ddc_valid_out;
    logic [FW-1:0] nco_ftw;
    logic          nco_ftw_load;
    logic          nco_phase_clr;
    logic          busy;
    logic          last_grant;
    logic [CW-1:0] retune_count;

    ddc_tune_controller #(.FTW_WIDTH(FW), .FLUSH_CYCLES(FL), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_ftw(host_req_ftw), .host_req_ready(host_req_ready),
        .scan_req_valid(scan_req_valid), .scan_req_ftw(scan_req_ftw), .scan_req_ready(scan_req_ready),
        .sample_valid(sample_valid), .ddc_valid_in(ddc_valid_in), .ddc_valid_out(ddc_valid_out),
        .nco_ftw(nco_ftw), .nco_ftw_load(nco_ftw_load), .nco_phase_clr(nco_phase_clr),
        .busy(busy), .last_grant(last_grant), .retune_count(retune_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a request is either waiting for a sample, or the
    // block is blanking for a number of remaining cycles, or it is idle.
    bit            m_waiting = 0;
    int            m_blank = 0;
    bit            m_last = 1;
    logic [FW-1:0] m_pend = '0;
    logic [FW-1:0] m_ftw = '0;
    bit            m_load = 0;
    logic [CW-1:0] m_count = '0;
    int            cyc = 0;

    function automatic int model_grant();
        if (host_req_valid && scan_req_valid) return m_last ? 0 : 1;
        if (host_req_valid) return 0;
        if (scan_req_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        cyc++;
        if (rst) begin
            m_waiting = 0; m_blank = 0; m_last = 1; m_ftw = '0; m_load = 0; m_count = '0; m_pend = '0;
        end else begin
            m_load = 0;
            if (m_blank > 0) begin
                m_blank--;
            end else if (m_waiting) begin
                if (sample_valid) begin
                    m_waiting = 0; m_ftw = m_pend; m_load = 1; m_count = m_count + 1'b1; m_blank = FL;
                end
            end else begin
                g = model_grant();
                if (g >= 0) begin
                    m_pend = (g == 1) ? scan_req_ftw : host_req_ftw;
                    m_last = (g == 1);
                    m_waiting = 1;
                end
            end
        end
    end

    bit log_en = 0;
    int grants[$];
    int gcycs[$];

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        bit idle;
        int g;
        idle = !m_waiting && (m_blank == 0);
        g = model_grant();
        chk("host_ready", 64'(host_req_ready), 64'(!rst && idle && g == 0));
        chk("scan_ready", 64'(scan_req_ready), 64'(!rst && idle && g == 1));
        chk("ddc_valid_out", 64'(ddc_valid_out), 64'(ddc_valid_in && m_blank == 0 && !rst));
        chk("busy", 64'(busy), 64'(!idle));
        chk("nco_ftw", 64'(nco_ftw), 64'(m_ftw));
        chk("nco_ftw_load", 64'(nco_ftw_load), 64'(m_load));
`ifdef DDC_TUNE_PHASE_CLR_EN
        chk("nco_phase_clr", 64'(nco_phase_clr), 64'(m_load));
`else
        chk("nco_phase_clr", 64'(nco_phase_clr), 64'(0));
`endif
        chk("last_grant", 64'(last_grant), 64'(m_last));
        chk("retune_count", 64'(retune_count), 64'(m_count));
        if (log_en && !rst) begin
            if (host_req_valid && host_req_ready) begin grants.push_back(0); gcycs.push_back(cyc); end
            if (scan_req_valid && scan_req_ready) begin grants.push_back(1); gcycs.push_back(cyc); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        host_req_valid = 0; scan_req_valid = 0; sample_valid = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        step(); step();
        rst = 0;
    endtask

    initial begin
        int loads;
        // reset values
        rst = 1; ddc_valid_in = 1;
        step(); step();
        #2;
        chk("rst_ddc_valid_out", 64'(ddc_valid_out), 64'(0));
        chk("rst_last_grant", 64'(last_grant), 64'(1));
        chk("rst_nco_ftw", 64'(nco_ftw), 64'(0));
        rst = 0;
        #1;
        chk("idle_ddc_valid_out", 64'(ddc_valid_out), 64'(1));
        step();

        // directed host retune: handshake in cycle T, sample at T+3
        host_req_valid = 1; host_req_ftw = 32'h1234_5678;
        #1 chk("T_host_ready", 64'(host_req_ready), 64'(1));
        step(); host_req_valid = 0;                 // T+1
        step();                                     // T+2
        step(); sample_valid = 1;                   // T+3
        step(); sample_valid = 0;                   // T+4
        #1;
        chk("T4_load", 64'(nco_ftw_load), 64'(1));
        chk("T4_ftw", 64'(nco_ftw), 64'h1234_5678);
        chk("T4_blank", 64'(ddc_valid_out), 64'(0));
        step();                                     // T+5
        #1;
        chk("T5_load", 64'(nco_ftw_load), 64'(0));
        chk("T5_blank", 64'(ddc_valid_out), 64'(0));
        step();                                     // T+6
        host_req_valid = 1;
        #1;
        chk("T6_host_ready", 64'(host_req_ready), 64'(1));
        chk("T6_count", 64'(retune_count), 64'(1));
        chk("T6_ddc_valid", 64'(ddc_valid_out), 64'(1));
        host_req_valid = 0;
        step();

        // both requesters held valid, sample always present
        log_en = 1;
        host_req_valid = 1; scan_req_valid = 1; sample_valid = 1;
        host_req_ftw = 32'hAAAA_0001; scan_req_ftw = 32'h5555_0002;
        repeat (40) step();
        quiet();
        log_en = 0;
        chk("alt_enough", 64'(grants.size() >= 8), 64'(1));
        if (grants.size() >= 1) chk("alt_first_scan", 64'(grants[0]), 64'(1));
        for (int i = 1; i < grants.size(); i++) begin
            chk("alt_toggle", 64'(grants[i] != grants[i-1]), 64'(1));
            chk("alt_period", 64'(gcycs[i] - gcycs[i-1]), 64'(FL + 2));
        end
        repeat (6) step();

        // scan request while busy is neither accepted nor queued
        do_reset();
        host_req_valid = 1; host_req_ftw = 32'hCAFE_0011;
        step();
        host_req_valid = 0; scan_req_valid = 1; scan_req_ftw = 32'hDEAD_0022;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_scan_ready", 64'(scan_req_ready), 64'(0));
            step();
        end
        scan_req_valid = 0; sample_valid = 1;
        step();
        sample_valid = 0;
        repeat (8) step();
        chk("busy_scan_count", 64'(retune_count), 64'(1));
        chk("busy_scan_ftw", 64'(nco_ftw), 64'hCAFE_0011);

        // reset while waiting for a sample, with a sample in the same cycle
        do_reset();
        host_req_valid = 1; host_req_ftw = 32'hBEEF_0033;
        step();
        host_req_valid = 0; sample_valid = 1; rst = 1;
        step();
        rst = 0; sample_valid = 0;
        #1;
        chk("rstmid_load", 64'(nco_ftw_load), 64'(0));
        chk("rstmid_ftw", 64'(nco_ftw), 64'(0));
        chk("rstmid_count", 64'(retune_count), 64'(0));
        step();
        chk("rstmid_load2", 64'(nco_ftw_load), 64'(0));

        // counter wrap with COUNT_WIDTH=4
        do_reset();
        host_req_valid = 1; sample_valid = 1; host_req_ftw = 32'h0000_0100;
        loads = 0;
        for (int i = 0; i < 200 && loads < 15; i++) begin
            step();
            if (nco_ftw_load) loads++;
        end
        chk("wrap_reach15", 64'(loads), 64'(15));
        chk("wrap_count15", 64'(retune_count), 64'hF);
        for (int i = 0; i < 20 && loads < 16; i++) begin
            step();
            if (nco_ftw_load) loads++;
        end
        chk("wrap_reach16", 64'(loads), 64'(16));
        chk("wrap_count0", 64'(retune_count), 64'(0));
        quiet();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            host_req_valid = 1'($urandom_range(0, 1));
            scan_req_valid = 1'($urandom_range(0, 1));
            host_req_ftw   = $urandom;
            scan_req_ftw   = $urandom;
            sample_valid   = ($urandom_range(0, 3) == 0);
            ddc_valid_in   = 1'($urandom_range(0, 1));
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        quiet();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
